// File: rtl/rv32_exec_ctrl.sv
// RV32I execute/control slice: decode, operand key-muxes, ALU, next-PC and memory controls, registered.
// Optional RV32_EXEC_TRACE_EN: prints one trace line per captured instruction (simulation only).
module rv32_exec_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     cmd,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  output logic [2:0]      op_imm,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] dnpc,
  output logic            en_wreg,
  output logic            load,
  output logic            store,
  output logic [7:0]      op_pmem,
  output logic [1:0]      op_load_sext,
  output logic            less,
  output logic            is_zero,
  output logic            illegal
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = cmd[6:0];
  assign funct3 = cmd[14:12];
  assign funct7 = cmd[31:25];

  logic unused_fields;
  assign unused_fields = ^{cmd[24:15], cmd[11:7]};

  alu_op_t         alu_op;
  logic [XLEN-1:0] op_a, op_b, alu_res, diff, n_dnpc;
  logic            dec_ill, dec_wreg, dec_load, dec_store, is_branch, cmp_unsigned;
  logic            less_raw, taken, alt_ok;
  logic [7:0]      dec_pmem;
  logic [1:0]      dec_sext;

  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC:            op_imm = 3'd3;
      OPC_JAL:                       op_imm = 3'd4;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: op_imm = 3'd0;
      OPC_STORE:                     op_imm = 3'd1;
      OPC_BRANCH:                    op_imm = 3'd2;
      default:                       op_imm = 3'd7;
    endcase
  end

  always_comb begin
    op_a         = src1;
    op_b         = imm;
    alu_op       = ALU_ADD;
    dec_ill      = 1'b0;
    dec_wreg     = 1'b0;
    dec_load     = 1'b0;
    dec_store    = 1'b0;
    is_branch    = 1'b0;
    cmp_unsigned = 1'b0;
    dec_sext     = 2'b00;
    alt_ok       = 1'b0;
    case (funct3[1:0])
      2'b00:   dec_pmem = 8'h01;
      2'b01:   dec_pmem = 8'h03;
      2'b10:   dec_pmem = 8'h0F;
      default: dec_pmem = 8'h00;
    endcase
    case (opcode)
      OPC_LUI:   begin op_a = '0; dec_wreg = 1'b1; end
      OPC_AUIPC: begin op_a = pc; dec_wreg = 1'b1; end
      OPC_JAL:   begin op_a = pc; op_b = XLEN'(4); dec_wreg = 1'b1; end
      OPC_JALR: begin
        op_a = pc; op_b = XLEN'(4); dec_wreg = 1'b1;
        dec_ill = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        op_b = src2; alu_op = ALU_SUB; is_branch = 1'b1;
        cmp_unsigned = (funct3[2:1] == 2'b11);
        dec_ill = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec_load = 1'b1; dec_wreg = 1'b1;
        dec_ill  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        dec_sext = (funct3 == 3'b010) ? 2'b00 : (funct3[2] ? 2'b10 : 2'b01);
      end
      OPC_STORE: begin
        dec_store = 1'b1;
        dec_ill   = (funct3 > 3'b010);
      end
      OPC_OP_IMM, OPC_OP: begin
        if (opcode == OPC_OP) op_b = src2;
        dec_wreg     = 1'b1;
        cmp_unsigned = (funct3 == 3'b011);
        case (funct3)
          3'b000: alu_op = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
        // funct7 only carries meaning for OP and the immediate shifts
        alt_ok = (funct3 == 3'b101) || (opcode == OPC_OP && funct3 == 3'b000);
        if (opcode == OPC_OP || funct3 == 3'b001 || funct3 == 3'b101)
          dec_ill = !((funct7 == 7'h00) || (funct7 == 7'h20 && alt_ok));
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign diff     = op_a - op_b;
  assign less_raw = cmp_unsigned ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = diff;
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(op_a < op_b);
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> op_b[4:0]);
      ALU_OR:   alu_res = op_a | op_b;
      default:  alu_res = op_a & op_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:         taken = (diff == '0);
      3'b001:         taken = (diff != '0);
      3'b100, 3'b110: taken = less_raw;
      3'b101, 3'b111: taken = !less_raw;
      default:        taken = 1'b0;
    endcase
    n_dnpc = pc + XLEN'(4);
    if (!dec_ill) begin
      if (opcode == OPC_JAL)             n_dnpc = pc + imm;
      else if (opcode == OPC_JALR)       n_dnpc = (src1 + imm) & ~XLEN'(1);
      else if (is_branch && taken)       n_dnpc = pc + imm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      result       <= '0;
      dnpc         <= '0;
      en_wreg      <= 1'b0;
      load         <= 1'b0;
      store        <= 1'b0;
      op_pmem      <= 8'h00;
      op_load_sext <= 2'b00;
      less         <= 1'b0;
      is_zero      <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result       <= dec_ill ? '0 : alu_res;
        dnpc         <= n_dnpc;
        en_wreg      <= dec_wreg && !dec_ill;
        load         <= dec_load && !dec_ill;
        store        <= dec_store && !dec_ill;
        op_pmem      <= ((dec_load || dec_store) && !dec_ill) ? dec_pmem : 8'h00;
        op_load_sext <= dec_ill ? 2'b00 : dec_sext;
        less         <= less_raw && !dec_ill;
        is_zero      <= dec_ill ? 1'b1 : (is_branch ? (diff == '0) : (alu_res == '0));
        illegal      <= dec_ill;
      end
    end
  end

`ifdef RV32_EXEC_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst && in_valid)
      $display("exec: opc=%b alu=%s a=%h b=%h result=%h dnpc=%h",
               opcode, alu_op.name(), op_a, op_b, dec_ill ? '0 : alu_res, n_dnpc);
  end
`else
  // trace disabled: no simulation-only logic
`endif
endmodule

// File: tb/tb_rv32_exec_ctrl.sv
// Self-checking bench for rv32_exec_ctrl: directed cases plus randomized instructions vs a reference model.
module tb_rv32_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] cmd = '0, pc = '0, src1 = '0, src2 = '0, imm = '0;
  logic [2:0]  op_imm;
  logic        out_valid, en_wreg, load, store, less, is_zero, illegal;
  logic [31:0] result, dnpc;
  logic [7:0]  op_pmem;
  logic [1:0]  op_load_sext;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] dnpc;
    logic        wreg, load, store;
    logic [7:0]  pmem;
    logic [1:0]  sext;
    logic        less, zero, ill;
  } exp_t;

  exp_t cur;
  logic cur_valid;

  rv32_exec_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cmd(cmd), .pc(pc),
    .src1(src1), .src2(src2), .imm(imm), .op_imm(op_imm), .out_valid(out_valid),
    .result(result), .dnpc(dnpc), .en_wreg(en_wreg), .load(load), .store(store),
    .op_pmem(op_pmem), .op_load_sext(op_load_sext), .less(less), .is_zero(is_zero),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic logic [2:0] imm_fmt(input logic [6:0] opc);
    case (opc)
      7'b0110111, 7'b0010111:            return 3'd3;
      7'b1101111:                        return 3'd4;
      7'b1100111, 7'b0000011, 7'b0010011: return 3'd0;
      7'b0100011:                        return 3'd1;
      7'b1100011:                        return 3'd2;
      default:                           return 3'd7;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] c, p, s1, s2, im);
    exp_t e;
    logic [31:0] a, b;
    logic [2:0] f3;
    logic [6:0] f7;
    logic uns, br, op, tk, alt_ok;
    e = '0; f3 = c[14:12]; f7 = c[31:25];
    a = s1; b = im; uns = 1'b0; br = 1'b0;
    e.dnpc = p + 4;
    case (c[6:0])
      7'b0110111: begin a = 0; e.result = im; e.wreg = 1; end
      7'b0010111: begin a = p; e.result = p + im; e.wreg = 1; end
      7'b1101111: begin a = p; b = 4; e.result = p + 4; e.dnpc = p + im; e.wreg = 1; end
      7'b1100111:
        if (f3 != 0) e.ill = 1;
        else begin a = p; b = 4; e.result = p + 4; e.dnpc = (s1 + im) & ~32'd1; e.wreg = 1; end
      7'b1100011:
        if (f3 == 2 || f3 == 3) e.ill = 1;
        else begin
          br = 1;
          e.result = s1 - s2;
          e.zero = (s1 == s2);
          e.less = (f3 >= 6) ? (s1 < s2) : ($signed(s1) < $signed(s2));
          case (f3)
            3'd0: tk = e.zero;
            3'd1: tk = !e.zero;
            3'd4, 3'd6: tk = e.less;
            default: tk = !e.less;
          endcase
          if (tk) e.dnpc = p + im;
        end
      7'b0000011:
        if (f3 == 3 || f3 == 6 || f3 == 7) e.ill = 1;
        else begin
          e.result = s1 + im; e.load = 1; e.wreg = 1;
          e.pmem = (f3[1:0] == 0) ? 8'h01 : (f3[1:0] == 1) ? 8'h03 : 8'h0F;
          e.sext = (f3 == 2) ? 2'b00 : (f3 >= 4) ? 2'b10 : 2'b01;
        end
      7'b0100011:
        if (f3 > 2) e.ill = 1;
        else begin
          e.result = s1 + im; e.store = 1;
          e.pmem = (f3 == 0) ? 8'h01 : (f3 == 1) ? 8'h03 : 8'h0F;
        end
      7'b0010011, 7'b0110011: begin
        op = (c[6:0] == 7'b0110011);
        if (op) b = s2;
        alt_ok = (f3 == 5) || (op && f3 == 0);
        if ((op || f3 == 1 || f3 == 5) && !(f7 == 0 || (f7 == 7'h20 && alt_ok))) e.ill = 1;
        e.wreg = 1;
        case (f3)
          3'd0: e.result = (op && f7[5]) ? a - b : a + b;
          3'd1: e.result = a << b[4:0];
          3'd2: e.result = ($signed(a) < $signed(b)) ? 1 : 0;
          3'd3: begin e.result = (a < b) ? 1 : 0; uns = 1; end
          3'd4: e.result = a ^ b;
          3'd5: e.result = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: e.result = a | b;
          default: e.result = a & b;
        endcase
      end
      default: e.ill = 1;
    endcase
    if (e.ill) begin
      e = '0; e.ill = 1; e.zero = 1; e.dnpc = p + 4;
    end else if (!br) begin
      e.less = uns ? (a < b) : ($signed(a) < $signed(b));
      e.zero = (e.result == 0);
    end
    return e;
  endfunction

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(cur_valid));
    chk("result", result, cur.result);
    chk("dnpc", dnpc, cur.dnpc);
    chk("en_wreg", 32'(en_wreg), 32'(cur.wreg));
    chk("load", 32'(load), 32'(cur.load));
    chk("store", 32'(store), 32'(cur.store));
    chk("op_pmem", 32'(op_pmem), 32'(cur.pmem));
    chk("op_load_sext", 32'(op_load_sext), 32'(cur.sext));
    chk("less", 32'(less), 32'(cur.less));
    chk("is_zero", 32'(is_zero), 32'(cur.zero));
    chk("illegal", 32'(illegal), 32'(cur.ill));
  endtask

  task automatic step(input logic v, input logic [31:0] c, p, s1, s2, im);
    @(negedge clk);
    in_valid = v; cmd = c; pc = p; src1 = s1; src2 = s2; imm = im;
    #1 chk("op_imm", 32'(op_imm), 32'(imm_fmt(c[6:0])));
    @(posedge clk);
    if (v) cur = model(c, p, s1, s2, im);
    cur_valid = v;
    #1 check_all();
  endtask

  localparam logic [6:0] OPCS [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
    7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};

  initial begin
    cur = '0; cur_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk); rst = 1'b1;

    step(1, 32'h00208033, 32'h40, 5, 7, 0);
    chk("add_res", result, 12); chk("add_dnpc", dnpc, 32'h44);
    step(1, mk(7'b0110011, 3'd0, 7'h20), 0, 3, 5, 0);
    chk("sub_res", result, 32'hFFFFFFFE);
    step(1, mk(7'b0110011, 3'd5, 7'h20), 0, 32'h80000000, 4, 0);
    chk("sra_res", result, 32'hF8000000);
    step(1, mk(7'b0110011, 3'd3, 7'h00), 0, 1, 32'hFFFFFFFF, 0);
    chk("sltu_res", result, 1);
    step(1, mk(7'b1100011, 3'd0, 7'h00), 32'h80000000, 9, 9, 32'h10);
    chk("beq_taken", dnpc, 32'h80000010); chk("beq_wreg", 32'(en_wreg), 0);
    step(1, mk(7'b1100011, 3'd0, 7'h00), 32'h80000000, 9, 8, 32'h10);
    chk("beq_not", dnpc, 32'h80000004);
    step(1, mk(7'b1100111, 3'd0, 7'h00), 32'h100, 32'h203, 0, 0);
    chk("jalr_res", result, 32'h104); chk("jalr_dnpc", dnpc, 32'h202);
    step(1, mk(7'b0110111, 3'd0, 7'h00), 0, 0, 0, 32'h12345000);
    chk("lui_res", result, 32'h12345000);
    step(1, mk(7'b0000011, 3'd4, 7'h00), 0, 32'h1000, 0, 4);
    chk("lbu_res", result, 32'h1004); chk("lbu_pmem", 32'(op_pmem), 32'h01);
    chk("lbu_sext", 32'(op_load_sext), 2);
    step(1, mk(7'b0100011, 3'd2, 7'h00), 0, 32'h2000, 0, 8);
    chk("sw_store", 32'(store), 1); chk("sw_pmem", 32'(op_pmem), 32'h0F);
    step(1, 32'h0000007F, 32'h200, 1, 2, 3);
    chk("ill_flag", 32'(illegal), 1); chk("ill_wreg", 32'(en_wreg), 0);
    step(0, 32'h00208033, 32'h40, 1, 1, 0);

    step(1, 32'h00208033, 32'h40, 5, 7, 0);
    @(negedge clk); #2 rst = 1'b0;
    #1 chk("rst_valid", 32'(out_valid), 0); chk("rst_res", result, 0); chk("rst_dnpc", dnpc, 0);
    in_valid = 1'b0; cur = '0; cur_valid = 1'b0;
    #1 rst = 1'b1;
    step(0, 32'h00208033, 32'h40, 5, 7, 0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] c, s1, s2;
      logic [6:0] f7;
      int k;
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: f7 = 7'h20;
        1: f7 = 7'($urandom);
        default: f7 = 7'h00;
      endcase
      c = {f7, 18'($urandom), OPCS[k]};
      if (k == 9) c[6:0] = 7'($urandom);
      s1 = $urandom;
      s2 = ($urandom_range(0, 3) == 0) ? s1 : $urandom;
      step($urandom_range(0, 7) != 0, c, $urandom, s1, s2, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
